// File: rtl/channel_mux.sv
// channel_mux: N:1 registered channel mux with valid/ready, fixed-select or round-robin grant.
// Optional MUX_PARITY_EN adds a registered even-parity output bit.
module channel_mux #(
    parameter int WIDTH = 5,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic                      out_parity
`endif
);
    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [SEL_W-1:0] ptr, grant, idx;
    logic             grant_ok, can_load, transfer;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_split
        assign chan_data[c] = in_data[c*WIDTH +: WIDTH];
    end
    assign can_load = !out_valid || out_ready;
    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant = '0;
        grant_ok = 1'b0;
        idx = '0;
        if (!mode) begin
            grant_ok = {1'b0, sel} < (SEL_W+1)'(CHANNELS);
            grant = grant_ok ? sel : '0;
        end else begin
            for (int k = CHANNELS-1; k >= 0; k--) begin
                idx = SEL_W'((int'(ptr) + k) % CHANNELS);
                if (in_valid[idx]) begin
                    grant = idx;
                    grant_ok = 1'b1;
                end
            end
        end
    end
    assign in_ready = (can_load && grant_ok) ? CHANNELS'(1) << grant : '0;
    assign transfer = can_load && grant_ok && in_valid[grant];
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
            ptr <= '0;
        end else if (can_load) begin
            out_valid <= transfer;
            if (transfer) begin
                out_data <= chan_data[grant];
                out_chan <= grant;
                if (mode) ptr <= (grant == SEL_W'(CHANNELS-1)) ? '0 : grant + SEL_W'(1);
            end
        end
    end
`ifdef MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) out_parity <= 1'b0;
        else if (transfer) out_parity <= ^chan_data[grant];
    end
`endif
endmodule
